// File: rtl/unary_multi_adder.sv
// unary_multi_adder: N-channel unary stream adder with early-decided scaled output.
// Define UNARY_MULTI_ADDER_BOUNDS_DBG_EN to expose the bound/projection debug ports.
module unary_multi_adder #(
  parameter int N_INPUTS    = 2,
  parameter int INPUT_WIDTH = 32,
  parameter int EPSILON     = 0,
  parameter int COUNT_WIDTH = $clog2(INPUT_WIDTH + 1),
  parameter int SUM_WIDTH   = $clog2(N_INPUTS * INPUT_WIDTH + 1)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic [N_INPUTS-1:0]    a,
  input  logic [N_INPUTS-1:0]    ready,
  output logic                   y,
  output logic                   valid,
  output logic                   busy,
  output logic                   done,
  output logic [COUNT_WIDTH-1:0] y_ones
`ifdef UNARY_MULTI_ADDER_BOUNDS_DBG_EN
  ,
  output logic [SUM_WIDTH-1:0]   dbg_lower,
  output logic [SUM_WIDTH-1:0]   dbg_upper,
  output logic [SUM_WIDTH+1:0]   dbg_proj,
  output logic [COUNT_WIDTH-1:0] dbg_y_count
`endif
);

  localparam int XW = SUM_WIDTH + 2;
  localparam logic [XW-1:0] W_X  = XW'(INPUT_WIDTH);
  localparam logic [XW-1:0] N_X  = XW'(N_INPUTS);
  localparam logic [XW-1:0] E2_X = XW'(2 * EPSILON);
  localparam logic [COUNT_WIDTH-1:0] W_C =
    COUNT_WIDTH'(INPUT_WIDTH);
  localparam logic [COUNT_WIDTH-1:0] W_LAST =
    COUNT_WIDTH'(INPUT_WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  state_t                 state;
  logic [COUNT_WIDTH-1:0] ones_q [N_INPUTS];
  logic [COUNT_WIDTH-1:0] cnt_q  [N_INPUTS];
  logic [COUNT_WIDTH-1:0] y_count;

  logic [XW-1:0] lower;
  logic [XW-1:0] upper;
  logic [XW-1:0] proj;
  logic [XW-1:0] lo2;
  logic [XW-1:0] up2;
  logic [XW-1:0] d_lo;
  logic [XW-1:0] d_up;
  logic          any_cnt;
  logic          emit;
  logic          emit_bit;

  always_comb begin
    lower   = '0;
    upper   = '0;
    any_cnt = 1'b0;
    for (int i = 0; i < N_INPUTS; i++) begin
      lower   = lower + XW'(ones_q[i]);
      upper   = upper + W_X - XW'(cnt_q[i])
              + XW'(ones_q[i]);
      any_cnt = any_cnt | (cnt_q[i] != '0);
    end
  end

  // Projection of the output so far, in doubled sum units
  assign proj = N_X * ((XW'(y_ones) << 1) + W_X
              - XW'(y_count));
  assign lo2  = lower << 1;
  assign up2  = upper << 1;
  assign d_lo = proj - lo2;
  assign d_up = up2 - proj;

  always_comb begin
    emit     = 1'b0;
    emit_bit = 1'b0;
    if (state == S_RUN && y_count < W_C && any_cnt) begin
      if (proj <= lo2) begin
        emit     = 1'b1;
        emit_bit = 1'b1;
      end else if (proj >= up2) begin
        emit     = 1'b1;
      end else if (d_lo <= E2_X && d_lo <= d_up) begin
        emit     = 1'b1;
        emit_bit = 1'b1;
      end else if (d_up <= E2_X) begin
        emit     = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= S_IDLE;
      for (int i = 0; i < N_INPUTS; i++) begin
        ones_q[i] <= '0;
        cnt_q[i]  <= '0;
      end
      y_ones  <= '0;
      y_count <= '0;
      y       <= 1'b0;
      valid   <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else if (start) begin
      state   <= S_RUN;
      for (int i = 0; i < N_INPUTS; i++) begin
        ones_q[i] <= '0;
        cnt_q[i]  <= '0;
      end
      y_ones  <= '0;
      y_count <= '0;
      y       <= 1'b0;
      valid   <= 1'b0;
      busy    <= 1'b1;
      done    <= 1'b0;
    end else begin
      case (state)
        S_RUN: begin
          for (int i = 0; i < N_INPUTS; i++) begin
            if (ready[i] && cnt_q[i] < W_C) begin
              cnt_q[i]  <= cnt_q[i] + 1'b1;
              ones_q[i] <= ones_q[i]
                         + COUNT_WIDTH'(a[i]);
            end
          end
          y     <= emit_bit;
          valid <= emit;
          if (emit) begin
            y_count <= y_count + 1'b1;
            y_ones  <= y_ones
                     + COUNT_WIDTH'(emit_bit);
            if (y_count == W_LAST) begin
              state <= S_DONE;
              busy  <= 1'b0;
              done  <= 1'b1;
            end
          end
        end
        default: begin
          valid <= 1'b0;
        end
      endcase
    end
  end

`ifdef UNARY_MULTI_ADDER_BOUNDS_DBG_EN
  assign dbg_lower   = lower[SUM_WIDTH-1:0];
  assign dbg_upper   = upper[SUM_WIDTH-1:0];
  assign dbg_proj    = proj;
  assign dbg_y_count = y_count;
`endif

endmodule

// File: tb/tb_unary_multi_adder.sv
// tb_unary_multi_adder: three configurations (N=2, N=4, N=2/EPSILON=8)
// driven in lockstep and checked against a sum-level reference model.
module tb_unary_multi_adder;

  localparam int W = 8;

  logic       clk;
  logic       reset;
  logic       start;
  logic [3:0] a;
  logic [3:0] ready;
  logic [2:0] y_w;
  logic [2:0] v_w;
  logic [2:0] b_w;
  logic [2:0] d_w;
  logic [3:0] yo_w [3];

  int n_cmp;
  int n_bad;
  int n_tick;

  int m_ones [3][4];
  int m_cnt  [3][4];
  int m_yo   [3];
  int m_yc   [3];
  int m_st   [3];
  bit m_v    [3];
  bit m_y    [3];

  unary_multi_adder #(
    .N_INPUTS(2), .INPUT_WIDTH(W), .EPSILON(0)
  ) u_n2 (
    .clk(clk), .reset(reset), .start(start),
    .a(a[1:0]), .ready(ready[1:0]),
    .y(y_w[0]), .valid(v_w[0]), .busy(b_w[0]),
    .done(d_w[0]), .y_ones(yo_w[0])
  );

  unary_multi_adder #(
    .N_INPUTS(4), .INPUT_WIDTH(W), .EPSILON(0)
  ) u_n4 (
    .clk(clk), .reset(reset), .start(start),
    .a(a), .ready(ready),
    .y(y_w[1]), .valid(v_w[1]), .busy(b_w[1]),
    .done(d_w[1]), .y_ones(yo_w[1])
  );

  unary_multi_adder #(
    .N_INPUTS(2), .INPUT_WIDTH(W), .EPSILON(8)
  ) u_eps (
    .clk(clk), .reset(reset), .start(start),
    .a(a[1:0]), .ready(ready[1:0]),
    .y(y_w[2]), .valid(v_w[2]), .busy(b_w[2]),
    .done(d_w[2]), .y_ones(yo_w[2])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int nk(int k);
    return (k == 1) ? 4 : 2;
  endfunction

  function automatic int ek(int k);
    return (k == 2) ? 8 : 0;
  endfunction

  function automatic logic [7:0] obs(int k);
    return {b_w[k], d_w[k], v_w[k],
            v_w[k] & y_w[k], yo_w[k]};
  endfunction

  function automatic logic [7:0] expv(int k);
    logic [3:0] yo;
    yo = 4'(m_yo[k]);
    return {m_st[k] == 1, m_st[k] == 2, m_v[k],
            m_v[k] & m_y[k], yo};
  endfunction

  function automatic bit all_done();
    return m_st[0] == 2 && m_st[1] == 2 && m_st[2] == 2;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 3; k++) begin
      for (int i = 0; i < 4; i++) begin
        m_ones[k][i] = 0;
        m_cnt[k][i]  = 0;
      end
      m_yo[k] = 0; m_yc[k] = 0; m_st[k] = 0;
      m_v[k]  = 0; m_y[k]  = 0;
    end
  endtask

  // Sum-unit bounds: output bit j carries weight n, decided early
  task automatic model_edge(input logic s,
                            input logic [3:0] aa,
                            input logic [3:0] rr);
    for (int k = 0; k < 3; k++) begin
      int n, e, lo, up, p;
      bit any, em, yb;
      n = nk(k); e = ek(k);
      if (s) begin
        for (int i = 0; i < 4; i++) begin
          m_ones[k][i] = 0; m_cnt[k][i] = 0;
        end
        m_yo[k] = 0; m_yc[k] = 0; m_st[k] = 1;
        m_v[k] = 0; m_y[k] = 0;
      end else if (m_st[k] == 1) begin
        lo = 0; up = 0; any = 0;
        for (int i = 0; i < n; i++) begin
          lo += m_ones[k][i];
          up += W - m_cnt[k][i] + m_ones[k][i];
          if (m_cnt[k][i] > 0) any = 1;
        end
        p = n * (2 * m_yo[k] + W - m_yc[k]);
        em = 0; yb = 0;
        if (m_yc[k] < W && any) begin
          if (p <= 2 * lo) begin
            em = 1; yb = 1;
          end else if (p >= 2 * up) begin
            em = 1;
          end else if (p - 2 * lo <= 2 * e &&
                       p - 2 * lo <= 2 * up - p) begin
            em = 1; yb = 1;
          end else if (2 * up - p <= 2 * e) begin
            em = 1;
          end
        end
        for (int i = 0; i < n; i++) begin
          if (rr[i] && m_cnt[k][i] < W) begin
            m_cnt[k][i]++;
            m_ones[k][i] += int'(aa[i]);
          end
        end
        m_v[k] = em; m_y[k] = yb;
        if (em) begin
          m_yc[k]++;
          m_yo[k] += int'(yb);
          if (m_yc[k] == W) m_st[k] = 2;
        end
      end else begin
        m_v[k] = 0;
      end
    end
  endtask

  task automatic tick(input logic s,
                      input logic [3:0] aa,
                      input logic [3:0] rr);
    start = s; a = aa; ready = rr;
    @(posedge clk);
    if (reset) model_edge(s, aa, rr);
    #1;
    n_tick++;
    start = 1'b0;
  endtask

  task automatic test_reset();
    start = 0; a = 0; ready = 0;
    reset = 1'b1;
    #2;
    reset = 1'b0;
    model_reset();
    #1;
    for (int k = 0; k < 3; k++) begin
      n_cmp++;
      if (obs(k) !== 8'h00) begin
        n_bad++;
        $display("FAIL reset dut%0d: got %b want %b",
                 k, obs(k), 8'h00);
      end
    end
    tick(1'b1, 4'hF, 4'hF);
    for (int k = 0; k < 3; k++) begin
      n_cmp++;
      if (obs(k) !== expv(k)) begin
        n_bad++;
        $display("FAIL reset_hold dut%0d: got %b want %b",
                 k, obs(k), expv(k));
      end
    end
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic test_pattern(input string nm,
                              input logic [3:0] aa,
                              input int ones0,
                              input int ones1);
    int beats [3];
    beats = '{0, 0, 0};
    tick(1'b1, 4'h0, 4'h0);
    for (int t = 0; t < 8 + 24; t++) begin
      if (t >= 8 && all_done()) break;
      tick(1'b0, aa, (t < 8) ? 4'hF : 4'h0);
      for (int k = 0; k < 3; k++) begin
        beats[k] += int'(v_w[k]);
        n_cmp++;
        if (obs(k) !== expv(k)) begin
          n_bad++;
          $display("FAIL %s dut%0d tick %0d: got %b want %b",
                   nm, k, n_tick, obs(k), expv(k));
        end
      end
    end
    n_cmp++;
    if (beats[0] != W || beats[1] != W || d_w !== 3'b111) begin
      n_bad++;
      $display("FAIL %s_beats: got %0d/%0d done %b want 8/8 111",
               nm, beats[0], beats[1], d_w);
    end
    n_cmp++;
    if (yo_w[0] != 4'(ones0) || yo_w[1] != 4'(ones1)) begin
      n_bad++;
      $display("FAIL %s_ones: got %0d/%0d want %0d/%0d",
               nm, yo_w[0], yo_w[1], ones0, ones1);
    end
  endtask

  task automatic test_stall();
    int eps_beats;
    eps_beats = 0;
    tick(1'b1, 4'h0, 4'h0);
    tick(1'b0, 4'h3, 4'h3);
    for (int t = 0; t < 5; t++) begin
      tick(1'b0, 4'h0, 4'h0);
      eps_beats += int'(v_w[2]);
      n_cmp++;
      if (v_w[0] !== 1'b0) begin
        n_bad++;
        $display("FAIL stall_valid tick %0d: got %b want 0",
                 n_tick, v_w[0]);
      end
      for (int k = 0; k < 3; k++) begin
        n_cmp++;
        if (obs(k) !== expv(k)) begin
          n_bad++;
          $display("FAIL stall dut%0d tick %0d: got %b want %b",
                   k, n_tick, obs(k), expv(k));
        end
      end
    end
    n_cmp++;
    if (eps_beats == 0) begin
      n_bad++;
      $display("FAIL stall_eps_beats: got 0 want >0");
    end
    for (int t = 0; t < 40 && !all_done(); t++) begin
      tick(1'b0, 4'($urandom), 4'hF);
      for (int k = 0; k < 3; k++) begin
        n_cmp++;
        if (obs(k) !== expv(k)) begin
          n_bad++;
          $display("FAIL stall_drain dut%0d tick %0d: got %b want %b",
                   k, n_tick, obs(k), expv(k));
        end
      end
    end
  endtask

  task automatic test_restart();
    tick(1'b1, 4'h0, 4'h0);
    for (int t = 0; t < 20 && m_yc[0] != 3; t++) begin
      tick(1'b0, 4'hF, 4'hF);
      for (int k = 0; k < 3; k++) begin
        n_cmp++;
        if (obs(k) !== expv(k)) begin
          n_bad++;
          $display("FAIL restart_pre dut%0d tick %0d: got %b want %b",
                   k, n_tick, obs(k), expv(k));
        end
      end
    end
    tick(1'b1, 4'hF, 4'hF);
    n_cmp++;
    if ({v_w[0], b_w[0], d_w[0], yo_w[0]} !== 7'b0100000) begin
      n_bad++;
      $display("FAIL restart_clear: got %b want %b",
               {v_w[0], b_w[0], d_w[0], yo_w[0]}, 7'b0100000);
    end
    // Zeros after the restart expose any counted start-cycle ones
    for (int t = 0; t < 8 + 24; t++) begin
      if (t >= 8 && all_done()) break;
      tick(1'b0, 4'h0, (t < 8) ? 4'hF : 4'h0);
      for (int k = 0; k < 3; k++) begin
        n_cmp++;
        if (obs(k) !== expv(k)) begin
          n_bad++;
          $display("FAIL restart_run dut%0d tick %0d: got %b want %b",
                   k, n_tick, obs(k), expv(k));
        end
      end
    end
    n_cmp++;
    if (yo_w[0] !== 4'd0 || d_w[0] !== 1'b1) begin
      n_bad++;
      $display("FAIL restart_end: got ones %0d done %b want 0 1",
               yo_w[0], d_w[0]);
    end
    for (int t = 0; t < 4; t++) begin
      tick(1'b0, 4'hF, 4'hF);
      n_cmp++;
      if (v_w !== 3'b000 || d_w !== 3'b111 ||
          yo_w[0] !== 4'd0) begin
        n_bad++;
        $display("FAIL after_done tick %0d: got v %b d %b ones %0d want 000 111 0",
                 n_tick, v_w, d_w, yo_w[0]);
      end
    end
  endtask

  task automatic test_overrun();
    tick(1'b1, 4'h0, 4'h0);
    for (int t = 0; t < 12 + 10 + 24; t++) begin
      logic [3:0] rr;
      if (t >= 22 && all_done()) break;
      rr = (t < 12) ? 4'b0001 : (t < 22) ? 4'b1110 : 4'b0000;
      tick(1'b0, 4'($urandom), rr);
      for (int k = 0; k < 3; k++) begin
        n_cmp++;
        if (obs(k) !== expv(k)) begin
          n_bad++;
          $display("FAIL overrun dut%0d tick %0d: got %b want %b",
                   k, n_tick, obs(k), expv(k));
        end
      end
    end
    n_cmp++;
    if (d_w !== 3'b111) begin
      n_bad++;
      $display("FAIL overrun_done: got %b want 111", d_w);
    end
  endtask

  task automatic test_async_reset();
    tick(1'b1, 4'h0, 4'h0);
    for (int t = 0; t < 6; t++) tick(1'b0, 4'($urandom), 4'hF);
    #2;
    reset = 1'b0;
    model_reset();
    #1;
    n_cmp++;
    if ({y_w, v_w, b_w, d_w} !== 12'h000 || yo_w[0] !== 4'd0) begin
      n_bad++;
      $display("FAIL async_reset: got y%b v%b b%b d%b ones %0d want all 0",
               y_w, v_w, b_w, d_w, yo_w[0]);
    end
    @(negedge clk);
    reset = 1'b1;
    tick(1'b0, 4'hF, 4'hF);
    for (int k = 0; k < 3; k++) begin
      n_cmp++;
      if (obs(k) !== expv(k)) begin
        n_bad++;
        $display("FAIL async_idle dut%0d: got %b want %b",
                 k, obs(k), expv(k));
      end
    end
  endtask

  task automatic test_random();
    for (int r = 0; r < 5; r++) begin
      tick(1'b1, 4'h0, 4'h0);
      for (int t = 0; t < 40; t++) begin
        tick(1'b0, 4'($urandom), 4'($urandom));
        for (int k = 0; k < 3; k++) begin
          n_cmp++;
          if (obs(k) !== expv(k)) begin
            n_bad++;
            $display("FAIL random dut%0d tick %0d: got %b want %b",
                     k, n_tick, obs(k), expv(k));
          end
        end
      end
    end
  endtask

  initial begin
    n_cmp = 0; n_bad = 0; n_tick = 0;
    reset = 1'b1; start = 0; a = 0; ready = 0;
    model_reset();
    test_reset();
    test_pattern("all_ones", 4'hF, 8, 8);
    test_pattern("all_zeros", 4'h0, 0, 0);
    test_pattern("mixed", 4'h3, 8, 4);
    test_stall();
    test_restart();
    test_overrun();
    test_async_reset();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
